// File: rtl/bbj_mul_pipe.sv
// bbj_mul_pipe: valid/ready pipelined multiplier with configurable operand signedness,
// latency, right-shift scaling and overflow flag. Define BBJ_MUL_PIPE_SAT_EN to saturate on overflow.
module bbj_mul_pipe #(
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 12,
    parameter int dout_WIDTH = 32,
    parameter int NUM_STAGE  = 2,
    parameter int A_SIGNED   = 1,
    parameter int B_SIGNED   = 0,
    parameter int SHIFT      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  out_ovf
);

    localparam int P_W      = din0_WIDTH + din1_WIDTH;
    localparam bit P_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);
    localparam int W_EXT    = (P_W > dout_WIDTH) ? P_W : dout_WIDTH;

    // Handshake: an operand pair transfers on a rising edge where in_valid & in_ready;
    // a result transfers where out_valid & out_ready. in_ready is combinational and
    // low whenever the pipe is frozen (ce=0) or the output is held by the consumer.
    logic stall;
    logic adv;

    assign stall    = out_valid & ~out_ready;
    assign adv      = ce & ~stall;
    assign in_ready = adv;

    // Both operands are extended to the full product width, so one unsigned
    // P_W-bit multiply yields the correct two's-complement or unsigned product.
    function automatic logic [P_W-1:0] mul(input logic [din0_WIDTH-1:0] a,
                                           input logic [din1_WIDTH-1:0] b);
        logic [P_W-1:0] ax;
        logic [P_W-1:0] bx;
        if (A_SIGNED != 0) ax = {{din1_WIDTH{a[din0_WIDTH-1]}}, a};
        else               ax = {{din1_WIDTH{1'b0}}, a};
        if (B_SIGNED != 0) bx = {{din0_WIDTH{b[din1_WIDTH-1]}}, b};
        else               bx = {{din0_WIDTH{1'b0}}, b};
        mul = ax * bx;
    endfunction

    // Product and valid bit presented to the final (narrowing) register.
    logic [P_W-1:0] p_fin;
    logic           v_fin;

    generate
        if (NUM_STAGE == 1) begin : g_single
            assign p_fin = mul(din0, din1);
            assign v_fin = in_valid & in_ready;
        end else begin : g_multi
            logic [din0_WIDTH-1:0] a_q;
            logic [din1_WIDTH-1:0] b_q;
            logic                  v1_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    v1_q <= 1'b0;
                end else if (adv) begin
                    a_q  <= din0;
                    b_q  <= din1;
                    v1_q <= in_valid & in_ready;
                end
            end

            if (NUM_STAGE == 2) begin : g_direct
                assign p_fin = mul(a_q, b_q);
                assign v_fin = v1_q;
            end else begin : g_deep
                // Stage 2 registers the product; the remaining stages only delay it.
                localparam int D = NUM_STAGE - 2;
                logic [P_W-1:0] p_q [D];
                logic [D-1:0]   pv_q;

                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        for (int i = 0; i < D; i++) p_q[i] <= '0;
                        pv_q <= '0;
                    end else if (adv) begin
                        p_q[0]  <= mul(a_q, b_q);
                        pv_q[0] <= v1_q;
                        for (int i = 1; i < D; i++) begin
                            p_q[i]  <= p_q[i-1];
                            pv_q[i] <= pv_q[i-1];
                        end
                    end
                end

                assign p_fin = p_q[D-1];
                assign v_fin = pv_q[D-1];
            end
        end
    endgenerate

    // Scale and narrow. s_ext is S extended to cover both P_W and dout_WIDTH, so the
    // overflow test is simply "re-extending the narrowed value does not give S back".
    logic [W_EXT-1:0]      s_ext;
    logic [dout_WIDTH-1:0] nar;
    logic                  ovf;

    always_comb begin
        if (P_SIGNED) s_ext = W_EXT'($signed(p_fin)) >>> SHIFT;
        else          s_ext = W_EXT'(p_fin) >> SHIFT;

        nar = s_ext[dout_WIDTH-1:0];

        if (P_SIGNED) ovf = (W_EXT'($signed(nar)) != s_ext);
        else          ovf = (W_EXT'(nar) != s_ext);

`ifdef BBJ_MUL_PIPE_SAT_EN
        if (ovf) begin
            nar = '1;
            if (P_SIGNED) begin
                nar[dout_WIDTH-1] = 1'b0;
                if (s_ext[W_EXT-1]) nar = ~nar;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
            out_ovf   <= 1'b0;
        end else if (adv) begin
            out_valid <= v_fin;
            dout      <= nar;
            out_ovf   <= ovf;
        end
    end

endmodule
